// File: rtl/dram_arbiter.sv
// Two-hart DRAM arbiter: captures each hart's load/store strobe into a slot and
// serialises the slots round-robin onto the single DRAM controller port.

module dram_arbiter_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  ctrl,
  input  logic        le,
  input  logic        we,
  input  logic        clr,
  output logic        busy,
  output logic [31:0] sel_addr,
  output logic [31:0] sel_wdata,
  output logic [2:0]  sel_ctrl,
  output logic        sel_store
);
  logic        pend, cap, store_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  ctrl_q;

  // A strobe while already pending is a protocol violation and is dropped.
  assign cap  = (le | we) & ~pend;
  assign busy = pend | cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      store_q <= 1'b0;
    end else if (cap) begin
      pend    <= 1'b1;
      addr_q  <= addr;
      wdata_q <= wdata;
      ctrl_q  <= ctrl;
      store_q <= we;
    end else if (clr) begin
      pend    <= 1'b0;
    end
  end

  // Bypass lets an idle arbiter issue the command the cycle after the strobe.
  assign sel_addr  = cap ? addr  : addr_q;
  assign sel_wdata = cap ? wdata : wdata_q;
  assign sel_ctrl  = cap ? ctrl  : ctrl_q;
  assign sel_store = cap ? we    : store_q;
endmodule

module dram_arbiter #(
  parameter int NHART   = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_h0_addr,
  input  logic [31:0] w_h1_addr,
  input  logic [31:0] w_h0_wdata,
  input  logic [31:0] w_h1_wdata,
  input  logic [2:0]  w_h0_ctrl,
  input  logic [2:0]  w_h1_ctrl,
  input  logic        w_h0_le,
  input  logic        w_h1_le,
  input  logic        w_h0_we,
  input  logic        w_h1_we,
  output logic        w_h0_busy,
  output logic        w_h1_busy,
  output logic [31:0] w_h_odata,
  output logic [31:0] w_grant,
  output logic [31:0] w_dram_addr,
  output logic [31:0] w_dram_wdata,
  output logic [2:0]  w_dram_ctrl,
  output logic        w_dram_le,
  output logic        w_dram_we_t,
  input  logic        w_dram_busy,
  input  logic [31:0] w_dram_odata,
  output logic        w_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAITHI, WAITLO, DONE} state_t;

  logic [NHART-1:0][31:0] req_addr, req_wdata, v_addr, v_wdata;
  logic [NHART-1:0][2:0]  req_ctrl, v_ctrl;
  logic [NHART-1:0]       req_le, req_we, busy, clr, v_store;

  state_t      state;
  logic        rr, cur, sel, cur_store, lowcnt, timed_out;
  logic [11:0] tcnt;

  assign req_addr  = {w_h1_addr,  w_h0_addr};
  assign req_wdata = {w_h1_wdata, w_h0_wdata};
  assign req_ctrl  = {w_h1_ctrl,  w_h0_ctrl};
  assign req_le    = {w_h1_le,    w_h0_le};
  assign req_we    = {w_h1_we,    w_h0_we};
  assign w_h0_busy = busy[0];
  assign w_h1_busy = busy[1];

  for (genvar i = 0; i < NHART; i++) begin : g_slot
    assign clr[i] = (state == DONE) && (cur == 1'(i));
    dram_arbiter_slot u_slot (
      .clk       (CLK),
      .rst       (RST),
      .addr      (req_addr[i]),
      .wdata     (req_wdata[i]),
      .ctrl      (req_ctrl[i]),
      .le        (req_le[i]),
      .we        (req_we[i]),
      .clr       (clr[i]),
      .busy      (busy[i]),
      .sel_addr  (v_addr[i]),
      .sel_wdata (v_wdata[i]),
      .sel_ctrl  (v_ctrl[i]),
      .sel_store (v_store[i])
    );
  end

  // rr only matters when both harts want the port.
  always_comb begin
    sel = rr;
    if (busy[0] != busy[1]) sel = busy[1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      rr           <= 1'b0;
      cur          <= 1'b0;
      cur_store    <= 1'b0;
      lowcnt       <= 1'b0;
      timed_out    <= 1'b0;
      tcnt         <= '0;
      w_grant      <= '0;
      w_dram_addr  <= '0;
      w_dram_wdata <= '0;
      w_dram_ctrl  <= '0;
      w_dram_le    <= 1'b0;
      w_dram_we_t  <= 1'b0;
      w_h_odata    <= '0;
      w_err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|busy) begin
          cur          <= sel;
          cur_store    <= v_store[sel];
          w_grant      <= {31'b0, sel};
          w_dram_addr  <= v_addr[sel];
          w_dram_wdata <= v_wdata[sel];
          w_dram_ctrl  <= v_ctrl[sel];
          w_dram_le    <= ~v_store[sel];
          w_dram_we_t  <= v_store[sel];
          state        <= ISSUE;
        end
        ISSUE: begin
          w_dram_le   <= 1'b0;
          w_dram_we_t <= 1'b0;
          tcnt        <= '0;
          lowcnt      <= 1'b0;
          timed_out   <= 1'b0;
          state       <= WAITHI;
        end
        WAITHI: begin
          tcnt <= tcnt + 12'd1;
          // A controller that never raises busy finishes after two quiet cycles.
          if (w_dram_busy) state <= WAITLO;
          else if (lowcnt) state <= DONE;
          else if (tcnt == 12'(TIMEOUT - 1)) begin
            w_err     <= 1'b1;
            timed_out <= 1'b1;
            state     <= DONE;
          end else lowcnt <= 1'b1;
        end
        WAITLO: begin
          tcnt <= tcnt + 12'd1;
          if (!w_dram_busy) state <= DONE;
          else if (tcnt == 12'(TIMEOUT - 1)) begin
            w_err     <= 1'b1;
            timed_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!cur_store) w_h_odata <= timed_out ? 32'h0 : w_dram_odata;
          rr    <= ~cur;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: behavioural DRAM, per-hart request queues and a
// strobe log checked against arbitration rules and cycle-exact latencies.

module tb_dram_arbiter;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [31:0] w_h0_addr, w_h1_addr, w_h0_wdata, w_h1_wdata;
  logic [2:0]  w_h0_ctrl, w_h1_ctrl;
  logic        w_h0_le, w_h1_le, w_h0_we, w_h1_we;
  logic        w_h0_busy, w_h1_busy, w_dram_le, w_dram_we_t, w_dram_busy, w_err;
  logic [31:0] w_h_odata, w_grant, w_dram_addr, w_dram_wdata, w_dram_odata;
  logic [2:0]  w_dram_ctrl;

  typedef struct {
    int          hart;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    bit          store;
    int          cyc;
  } ent_t;

  ent_t        log_q[$];
  ent_t        req_q[2][$];
  int          errors = 0, checks = 0, cyc = 0, lat_fix = 3, rem = 0;
  bit          stuck = 0;
  logic        dbusy = 1'b0, b0p = 1'b0, b1p = 1'b0;
  logic [31:0] dodata = '0;

  always #5 CLK = ~CLK;

  dram_arbiter #(.NHART(2), .TIMEOUT(4095)) dut (
    .CLK(CLK), .RST(RST),
    .w_h0_addr(w_h0_addr), .w_h1_addr(w_h1_addr),
    .w_h0_wdata(w_h0_wdata), .w_h1_wdata(w_h1_wdata),
    .w_h0_ctrl(w_h0_ctrl), .w_h1_ctrl(w_h1_ctrl),
    .w_h0_le(w_h0_le), .w_h1_le(w_h1_le),
    .w_h0_we(w_h0_we), .w_h1_we(w_h1_we),
    .w_h0_busy(w_h0_busy), .w_h1_busy(w_h1_busy),
    .w_h_odata(w_h_odata), .w_grant(w_grant),
    .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
    .w_dram_le(w_dram_le), .w_dram_we_t(w_dram_we_t),
    .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata), .w_err(w_err)
  );

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (a == 32'h8000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_1234);
  endfunction

  // DRAM: busy rises the cycle after a strobe and stays up for lat cycles.
  assign w_dram_busy  = dbusy;
  assign w_dram_odata = dodata;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      dbusy <= 1'b0; rem <= 0; dodata <= '0;
    end else if (w_dram_le || w_dram_we_t) begin
      dbusy <= 1'b1;
      rem   <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
      if (w_dram_le) dodata <= exp_rd(w_dram_addr);
    end else if (rem > 1) rem <= rem - 1;
    else begin
      rem <= 0; dbusy <= stuck;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST && (w_dram_le || w_dram_we_t))
      log_q.push_back('{hart: int'(w_grant), addr: w_dram_addr, wdata: w_dram_wdata,
                        ctrl: w_dram_ctrl, store: w_dram_we_t, cyc: cyc});
  end

  always @(negedge CLK) begin
    assert (!((w_h0_le || w_h0_we) && b0p)) else $error("protocol: hart 0 strobed while busy");
    assert (!((w_h1_le || w_h1_we) && b1p)) else $error("protocol: hart 1 strobed while busy");
    b0p <= w_h0_busy;
    b1p <= w_h1_busy;
  end

  function automatic logic hbusy(input int h);
    return (h == 0) ? w_h0_busy : w_h1_busy;
  endfunction

  function automatic ent_t mk(input int h, input logic [31:0] a, input logic [31:0] d, input bit st);
    ent_t r;
    r.hart = h; r.addr = a; r.wdata = d; r.ctrl = a[2:0] ^ 3'b101; r.store = st; r.cyc = 0;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_h(input int h, input ent_t r, input bit on);
    if (h == 0) begin
      w_h0_addr = r.addr; w_h0_wdata = r.wdata; w_h0_ctrl = r.ctrl;
      w_h0_we = on & r.store; w_h0_le = on & ~r.store;
    end else begin
      w_h1_addr = r.addr; w_h1_wdata = r.wdata; w_h1_ctrl = r.ctrl;
      w_h1_we = on & r.store; w_h1_le = on & ~r.store;
    end
  endtask

  task automatic wait_free(input int h, input int lim, output int fall);
    int wc = 0;
    do begin @(negedge CLK); wc++; end while (hbusy(h) && wc < lim);
    fall = hbusy(h) ? -1 : cyc;
  endtask

  task automatic do_reset();
    RST = 1'b1; stuck = 0;
    set_h(0, mk(0, 0, 0, 0), 1'b0);
    set_h(1, mk(1, 0, 0, 0), 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    log_q.delete(); req_q[0].delete(); req_q[1].delete();
  endtask

  // Hart driver: re-strobes as soon as its busy drops (plus optional random gap).
  task automatic drive_hart(input int h, input int n, input bit gaps);
    ent_t r;
    int   fall;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 4)) @(posedge CLK);
      tick();
      r = mk(h, $urandom, $urandom, 1'($urandom_range(0, 1)));
      r.ctrl = 3'($urandom_range(0, 7));
      set_h(h, r, 1'b1);
      req_q[h].push_back(r);
      tick();
      set_h(h, r, 1'b0);
      wait_free(h, 400, fall);
      checks++;
      if (fall < 0) begin
        errors++;
        $display("FAIL h%0d_done_wait: busy still 1 after 400 cycles, required 0", h);
      end else if (!r.store && w_h_odata !== exp_rd(r.addr)) begin
        errors++;
        $display("FAIL h%0d_load_data: odata=%h, required %h", h, w_h_odata, exp_rd(r.addr));
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_h(0, mk(0, 0, 0, 0), 1'b0);
    set_h(1, mk(1, 0, 0, 0), 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({w_h0_busy, w_h1_busy} !== 2'b00) begin errors++;
      $display("FAIL reset_busy: got %b%b, required 00", w_h0_busy, w_h1_busy); end
    checks++;
    if (w_grant !== 32'h0) begin errors++;
      $display("FAIL reset_grant: got %h, required 0", w_grant); end
    checks++;
    if ({w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t} !== 69'h0) begin errors++;
      $display("FAIL reset_dram: addr=%h wdata=%h ctrl=%h le=%b we=%b, required all 0",
               w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t); end
    checks++;
    if (w_h_odata !== 32'h0 || w_err !== 1'b0) begin errors++;
      $display("FAIL reset_odata_err: odata=%h err=%b, required 0 0", w_h_odata, w_err); end
    #1 RST = 1'b0;
  endtask

  task automatic test_single_load();
    ent_t r;
    int   t, fall;
    do_reset(); lat_fix = 3;
    r = mk(0, 32'h8000_1000, 32'h0, 0);
    tick(); set_h(0, r, 1'b1); t = cyc;
    @(negedge CLK);
    checks++;
    if (w_h0_busy !== 1'b1) begin errors++;
      $display("FAIL single_busy_strobe_cycle: got %b, required 1", w_h0_busy); end
    tick(); set_h(0, r, 1'b0);
    wait_free(0, 50, fall);
    checks++;
    if (log_q.size() != 1 || log_q[0].cyc != t + 1 || log_q[0].addr !== r.addr ||
        log_q[0].store || log_q[0].hart != 0) begin errors++;
      $display("FAIL single_issue: strobes=%0d first at +%0d, required 1 load at +1 addr %h",
               log_q.size(), (log_q.size() > 0) ? log_q[0].cyc - t : -1, r.addr); end
    checks++;
    if (fall != t + 7) begin errors++;
      $display("FAIL single_busy_fall: busy low at +%0d, required +7", fall - t); end
    checks++;
    if (w_h_odata !== 32'hDEAD_BEEF || w_grant !== 32'h0) begin errors++;
      $display("FAIL single_data_grant: odata=%h grant=%h, required deadbeef 0", w_h_odata, w_grant); end
  endtask

  task automatic test_simultaneous();
    ent_t r0, r1;
    int   f0, f1;
    do_reset(); lat_fix = 0;
    r0 = mk(0, 32'h100, 32'h11, 1);
    r1 = mk(1, 32'h200, 32'h0, 0);
    tick(); set_h(0, r0, 1'b1); set_h(1, r1, 1'b1);
    tick(); set_h(0, r0, 1'b0); set_h(1, r1, 1'b0);
    wait_free(0, 100, f0);
    wait_free(1, 100, f1);
    checks++;
    if (f0 < 0 || f1 < 0 || log_q.size() != 2) begin errors++;
      $display("FAIL simul_count: strobes=%0d falls=%0d/%0d, required 2 strobes", log_q.size(), f0, f1);
    end else begin
      checks++;
      if (log_q[0].hart != 0 || !log_q[0].store || log_q[0].addr !== 32'h100 || log_q[0].wdata !== 32'h11) begin
        errors++;
        $display("FAIL simul_first: hart=%0d st=%b addr=%h wdata=%h, required 0 1 100 11",
                 log_q[0].hart, log_q[0].store, log_q[0].addr, log_q[0].wdata); end
      checks++;
      if (log_q[1].hart != 1 || log_q[1].store || log_q[1].addr !== 32'h200) begin errors++;
        $display("FAIL simul_second: hart=%0d st=%b addr=%h, required 1 0 200",
                 log_q[1].hart, log_q[1].store, log_q[1].addr); end
      checks++;
      if (w_h_odata !== exp_rd(32'h200)) begin errors++;
        $display("FAIL simul_odata: got %h, required %h", w_h_odata, exp_rd(32'h200)); end
    end
  endtask

  task automatic test_store_wins();
    int fall;
    do_reset(); lat_fix = 1;
    tick();
    w_h0_addr = 32'h300; w_h0_wdata = 32'h33; w_h0_ctrl = 3'd2; w_h0_le = 1'b1; w_h0_we = 1'b1;
    tick(); w_h0_le = 1'b0; w_h0_we = 1'b0;
    wait_free(0, 50, fall);
    checks++;
    if (fall < 0 || log_q.size() != 1 || !log_q[0].store || log_q[0].wdata !== 32'h33) begin errors++;
      $display("FAIL store_wins: strobes=%0d store=%b, required 1 strobe store=1",
               log_q.size(), (log_q.size() > 0) ? log_q[0].store : 1'b0); end
  endtask

  task automatic test_fairness();
    do_reset(); lat_fix = 0;
    fork
      drive_hart(0, 8, 1'b0);
      drive_hart(1, 8, 1'b0);
    join
    repeat (3) tick();
    checks++;
    if (log_q.size() != 16) begin errors++;
      $display("FAIL fair_count: strobes=%0d, required 16", log_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        ent_t e, r;
        e = log_q[i];
        r = req_q[i % 2][i / 2];
        checks++;
        if (e.hart != i % 2 || e.addr !== r.addr || e.wdata !== r.wdata ||
            e.ctrl !== r.ctrl || e.store !== r.store) begin errors++;
          $display("FAIL fair_issue%0d: hart=%0d addr=%h st=%b, required hart=%0d addr=%h st=%b",
                   i, e.hart, e.addr, e.store, i % 2, r.addr, r.store); end
      end
    end
  endtask

  task automatic test_queued();
    ent_t r0, r1;
    int   t, fall;
    do_reset(); lat_fix = 3;
    r0 = mk(0, 32'h0000_0A00, 32'hCAFE_0001, 1);
    r1 = mk(1, 32'h0000_0B00, 32'h0, 0);
    tick(); set_h(0, r0, 1'b1); t = cyc;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) set_h(0, r0, 1'b0);
      if (k == 3) set_h(1, r1, 1'b1);
      if (k == 4) set_h(1, r1, 1'b0);
      @(negedge CLK);
      checks++;
      if (w_dram_addr !== r0.addr || w_dram_wdata !== r0.wdata) begin errors++;
        $display("FAIL queued_hold+%0d: addr=%h wdata=%h, required %h %h",
                 k, w_dram_addr, w_dram_wdata, r0.addr, r0.wdata); end
      if (k == 3) begin
        checks++;
        if (w_h1_busy !== 1'b1) begin errors++;
          $display("FAIL queued_h1_busy: got %b, required 1", w_h1_busy); end
      end
    end
    wait_free(1, 50, fall);
    checks++;
    if (fall < 0 || log_q.size() != 2 || log_q[1].hart != 1 || log_q[1].cyc != t + 8) begin errors++;
      $display("FAIL queued_h1_issue: strobes=%0d second at +%0d, required 2 with h1 at +8",
               log_q.size(), (log_q.size() > 1) ? log_q[1].cyc - t : -1); end
  endtask

  task automatic test_timeout();
    ent_t r;
    int   t, fall;
    do_reset(); lat_fix = 2;
    r = mk(0, 32'h0000_1234, 32'h0, 0);
    tick(); set_h(0, r, 1'b1);
    tick(); set_h(0, r, 1'b0);
    wait_free(0, 50, fall);
    checks++;
    if (fall < 0 || w_h_odata !== exp_rd(r.addr) || w_err !== 1'b0) begin errors++;
      $display("FAIL timeout_prime: odata=%h err=%b, required %h 0", w_h_odata, w_err, exp_rd(r.addr)); end
    stuck = 1;
    r = mk(0, 32'h0000_5678, 32'h0, 0);
    tick(); set_h(0, r, 1'b1); t = cyc;
    tick(); set_h(0, r, 1'b0);
    wait_free(0, 5000, fall);
    checks++;
    if (fall < t + 4096 || fall > t + 4100) begin errors++;
      $display("FAIL timeout_fall: busy low at +%0d, required +4096..+4100", (fall < 0) ? -1 : fall - t); end
    checks++;
    if (w_err !== 1'b1 || w_h_odata !== 32'h0) begin errors++;
      $display("FAIL timeout_flag: err=%b odata=%h, required 1 0", w_err, w_h_odata); end
    stuck = 0;
  endtask

  task automatic test_reset_mid();
    ent_t r;
    do_reset(); lat_fix = 3;
    r = mk(1, 32'h4000_0040, 32'h77, 0);
    tick(); set_h(1, r, 1'b1);
    tick(); set_h(1, r, 1'b0);
    repeat (2) tick();
    checks++;
    if (w_dram_addr !== r.addr || w_grant !== 32'h1 || w_h1_busy !== 1'b1) begin errors++;
      $display("FAIL rstmid_pre: addr=%h grant=%h busy=%b, required %h 1 1",
               w_dram_addr, w_grant, w_h1_busy, r.addr); end
    RST = 1'b1;
    #1;
    checks++;
    if (w_grant !== 32'h0 || w_dram_addr !== 32'h0 || w_dram_wdata !== 32'h0 || w_dram_ctrl !== 3'h0 ||
        w_h1_busy !== 1'b0 || w_h0_busy !== 1'b0 || w_dram_le !== 1'b0 || w_h_odata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: grant=%h addr=%h ctrl=%h busy=%b%b odata=%h, required all 0",
               w_grant, w_dram_addr, w_dram_ctrl, w_h1_busy, w_h0_busy, w_h_odata); end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    log_q.delete(); req_q[1].delete();
    drive_hart(1, 2, 1'b0);
    checks++;
    if (log_q.size() != 2 || log_q[0].hart != 1 || log_q[0].addr !== req_q[1][0].addr ||
        log_q[1].addr !== req_q[1][1].addr) begin errors++;
      $display("FAIL rstmid_after: strobes=%0d, required 2 from hart 1 matching requests", log_q.size()); end
  endtask

  task automatic test_random();
    int idx[2];
    do_reset(); lat_fix = 0;
    fork
      drive_hart(0, 10, 1'b1);
      drive_hart(1, 10, 1'b1);
    join
    repeat (3) tick();
    idx[0] = 0; idx[1] = 0;
    foreach (log_q[i]) begin
      ent_t e, r;
      int   h;
      e = log_q[i];
      h = e.hart;
      checks++;
      if (h < 0 || h > 1 || idx[h] >= req_q[h].size()) begin errors++;
        $display("FAIL rand_extra%0d: unexpected strobe from grant %0d", i, h);
      end else begin
        r = req_q[h][idx[h]];
        idx[h]++;
        if (e.addr !== r.addr || e.wdata !== r.wdata || e.ctrl !== r.ctrl || e.store !== r.store) begin
          errors++;
          $display("FAIL rand_issue%0d: h%0d addr=%h st=%b, required addr=%h st=%b",
                   i, h, e.addr, e.store, r.addr, r.store); end
      end
    end
    checks++;
    if (idx[0] != 10 || idx[1] != 10) begin errors++;
      $display("FAIL rand_count: served %0d/%0d, required 10/10", idx[0], idx[1]); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_simultaneous();
    test_store_wins();
    test_fairness();
    test_queued();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-hart DRAM access arbiter; sits directly downstream of two m_cpummu instances and upstream of the single DRAM controller.
- Captures each hart's DRAM strobe (w_dram_le / w_dram_we_t) together with its command, and serialises the commands round-robin onto one DRAM port.
- Returns read data and a per-hart busy signal, and drives w_grant with the hart id currently owning the DRAM.

Parameters:
- NHART, 2, number of requesters; fixed at 2 for this revision.
- TIMEOUT, 4095, cycles allowed to wait for DRAM busy to complete before flagging an error.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- w_h0_addr / w_h1_addr  input  32  DRAM address from hart 0 / hart 1.
- w_h0_wdata / w_h1_wdata  input  32  write data.
- w_h0_ctrl / w_h1_ctrl  input  3  access size/sign control.
- w_h0_le / w_h1_le  input  1  one-cycle load strobe.
- w_h0_we / w_h1_we  input  1  one-cycle store strobe.
- w_h0_busy / w_h1_busy  output  1  request pending or in service.
- w_h_odata  output  32  read data of the last completed load, shared by both harts.
- w_grant  output  32  hart id owning the DRAM port.
- w_dram_addr  output  32  address to controller.
- w_dram_wdata  output  32  write data to controller.
- w_dram_ctrl  output  3  control to controller.
- w_dram_le  output  1  one-cycle load strobe to controller.
- w_dram_we_t  output  1  one-cycle store strobe to controller.
- w_dram_busy  input  1  controller busy.
- w_dram_odata  input  32  controller read data.
- w_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, RST=1): state IDLE; pending flags 0; rr pointer 0; w_grant=0; all DRAM outputs 0; w_hN_busy=0; w_h_odata=0; w_err=0.
- Capture:
  - A cycle with w_hN_le|w_hN_we latches addr, wdata, ctrl and type into slot N and sets pend[N].
  - w_hN_busy is asserted combinationally in the strobe cycle and stays 1 until that hart's DONE cycle inclusive.
  - A strobe while pend[N]=1 is a protocol violation: it is ignored, and the bench asserts it never happens.
  - If le and we are both high, the store wins.
- States:
  - IDLE: if any pend bit is set, select a hart. When both are pending, pick rr (the hart not served last); otherwise pick the single pending hart. Set w_grant to the selected hart -> ISSUE.
  - ISSUE: drive the slot's addr/wdata/ctrl and a one-cycle w_dram_le or w_dram_we_t -> WAITHI.
  - WAITHI: wait for w_dram_busy=1 -> WAITLO. If busy was already low this cycle and stays low for 2 cycles, treat the access as complete -> DONE.
  - WAITLO: wait for w_dram_busy=0 -> DONE.
  - DONE: for a load, capture w_dram_odata into w_h_odata. Clear pend[grant], deassert w_hN_busy next cycle, rr <= other hart -> IDLE.
- Command outputs stay stable from ISSUE through DONE.
- w_grant changes only on IDLE -> ISSUE and holds its last value while idle.
- Latency with an idle arbiter and single-cycle DRAM busy pulse: strobe at cycle t; ISSUE at t+1; busy high at t+2; busy low at t+3; DONE at t+4; w_hN_busy low at t+5.
- Simultaneous strobes from both harts in the same cycle: both are captured; rr decides order; the second hart is issued one cycle after the first returns to IDLE.
- A new strobe from the hart being served cannot arrive, since its busy is high.
- The other hart may strobe at any time; it is captured and waits.
- Timeout: a 12-bit counter runs in WAITHI/WAITLO. On reaching TIMEOUT, set w_err and force DONE, returning odata=0 for a load.
- Reset mid-transaction: all state clears immediately; outstanding requests are lost and busies drop.

Test Plan:
- Single load: h0 le, addr 0x80001000, DRAM returns 0xDEADBEEF after a 3-cycle busy -> w_dram_le pulse at t+1 with addr 0x80001000; w_h_odata=0xDEADBEEF; h0_busy low 1 cycle after DONE; w_grant=0.
- Simultaneous: h0 we (0x100, 0x11) and h1 le (0x200) in the same cycle after reset -> h0 issued first (rr=0), then h1; w_grant goes 0 then 1; exactly one DRAM strobe each.
- Fairness: both harts strobe repeatedly for 8 requests each -> issue order strictly alternates 0,1,0,1...
- Queued request: h1 strobes while h0 is in WAITLO -> h1_busy high immediately; h1 issued the cycle after h0 returns to IDLE; h0 addr and wdata unchanged on the DRAM port until h0's DONE.
- Timeout: w_dram_busy stuck at 1 after an h0 load -> after 4095 cycles w_err=1, h0_busy drops, w_h_odata=0.
- Async reset asserted in WAITLO -> all outputs 0 in the same cycle without waiting for a clock edge; after release, a new h1 request is served normally.
